mem_bus_arbiter: RTL

Shares the single external memory bus between the CPU bus controller and the debug monitor master. The CPU owns the bus by default, with a zero-latency combinational pass-through of its address, data and strobes. When the debug master requests the bus, the arbiter waits for an instruction boundary, freezes the core with CPU_HOLD, and then runs timed single-word or single-byte debug read/write cycles with a REQ/GNT and STB/ACK handshake. Sits between busController outputs and the memory pins.

---
 rtl/mem_bus_arbiter_pkg.sv | 33 +++
 rtl/mem_bus_arbiter_wait_timer.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter between the CPU bus
// controller and the debug monitor master.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned BE_W    = 2;
  localparam int unsigned TIMER_W = 3;

  // Debug byte-enable encodings ([1]=high byte, [0]=low byte)
  localparam logic [BE_W-1:0] DBG_BE_NONE = 2'b00;
  localparam logic [BE_W-1:0] DBG_BE_LO   = 2'b01;
  localparam logic [BE_W-1:0] DBG_BE_HI   = 2'b10;
  localparam logic [BE_W-1:0] DBG_BE_BOTH = 2'b11;

  typedef enum logic [2:0] {
    ARB_ST_CPU_OWN     = 3'd0,
    ARB_ST_HOLD_WAIT   = 3'd1,
    ARB_ST_DBG_IDLE    = 3'd2,
    ARB_ST_DBG_SETUP   = 3'd3,
    ARB_ST_DBG_STROBE  = 3'd4,
    ARB_ST_DBG_HOLDOFF = 3'd5
  } arb_state_t;

  // Debug command captured on DBG_STB
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dbg_cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_wait_timer.sv
// Loadable count-down timer with zero flag, used to time bus strobe widths
// and memory wait states.
module mem_bus_arbiter_wait_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between the CPU (default owner, combinational
// pass-through) and the debug master (timed, registered-strobe single cycles).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DOUT,
  input  logic              CPU_RDN,
  input  logic              CPU_WRN0,
  input  logic              CPU_WRN1,
  input  logic              CPU_IDLE,
  output logic              CPU_HOLD,
  input  logic              DBG_REQ,
  output logic              DBG_GNT,
  input  logic              DBG_STB,
  input  logic              DBG_WE,
  input  logic [BE_W-1:0]   DBG_BE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic              DBG_ACK,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DOUT,
  input  logic [DATA_W-1:0] MEM_DIN,
  output logic              MEM_RDN,
  output logic              MEM_WRN0,
  output logic              MEM_WRN1
);

  if (WAIT_STATES > ((1 << TIMER_W) - 1)) begin : g_wait_states_check
    $error("mem_bus_arbiter: WAIT_STATES must be in 0..7");
  end

  arb_state_t        state, state_d;
  dbg_cmd_t          cmd_q, cmd_d;
  logic              gnt_q, gnt_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdn_q, rdn_d;
  logic              wrn0_q, wrn0_d;
  logic              wrn1_q, wrn1_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              strobe_next;
  logic              cpu_path;

  mem_bus_arbiter_wait_timer #(
    .W (TIMER_W)
  ) u_wait_timer (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (tmr_load),
    .load_val (TIMER_W'(WAIT_STATES)),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero)
  );

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= ARB_ST_CPU_OWN;
      cmd_q   <= '0;
      gnt_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      rdn_q   <= 1'b1;
      wrn0_q  <= 1'b1;
      wrn1_q  <= 1'b1;
    end else begin
      state   <= state_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rdn_q   <= rdn_d;
      wrn0_q  <= wrn0_d;
      wrn1_q  <= wrn1_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d  = state;
    cmd_d    = cmd_q;
    gnt_d    = gnt_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    unique case (state)
      ARB_ST_CPU_OWN: begin
        if (DBG_REQ) state_d = ARB_ST_HOLD_WAIT;
      end
      ARB_ST_HOLD_WAIT: begin
        if (!DBG_REQ) begin
          state_d = ARB_ST_CPU_OWN;
        end else if (CPU_IDLE) begin
          state_d = ARB_ST_DBG_IDLE;
          gnt_d   = 1'b1;
        end
      end
      ARB_ST_DBG_IDLE: begin
        // A strobe in the same cycle as a request drop defers the release.
        if (DBG_STB) begin
          cmd_d.we    = DBG_WE;
          cmd_d.be    = DBG_BE;
          cmd_d.addr  = DBG_ADDR;
          cmd_d.wdata = DBG_WDATA;
          state_d     = ARB_ST_DBG_SETUP;
        end else if (!DBG_REQ) begin
          state_d = ARB_ST_CPU_OWN;
          gnt_d   = 1'b0;
        end
      end
      ARB_ST_DBG_SETUP: begin
        state_d  = ARB_ST_DBG_STROBE;
        tmr_load = 1'b1;
      end
      ARB_ST_DBG_STROBE: begin
        if (tmr_zero) begin
          state_d = ARB_ST_DBG_HOLDOFF;
          ack_d   = 1'b1;
          if (!cmd_q.we) rdata_d = MEM_DIN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ARB_ST_DBG_HOLDOFF: begin
        state_d = ARB_ST_DBG_IDLE;
      end
      default: begin
        state_d = ARB_ST_CPU_OWN;
        gnt_d   = 1'b0;
      end
    endcase

    // Strobe flops are low exactly in the cycles spent in DBG_STROBE.
    strobe_next = (state_d == ARB_ST_DBG_STROBE);
    rdn_d       = ~(strobe_next & ~cmd_q.we);
    wrn0_d      = ~(strobe_next & cmd_q.we & cmd_q.be[0]);
    wrn1_d      = ~(strobe_next & cmd_q.we & cmd_q.be[1]);
  end

  assign cpu_path = (state == ARB_ST_CPU_OWN) || (state == ARB_ST_HOLD_WAIT);

  // Memory pin mux; strobes are forced inactive while reset is asserted.
  always_comb begin
    if (cpu_path) begin
      MEM_ADDR = CPU_ADDR;
      MEM_DOUT = CPU_DOUT;
      MEM_RDN  = CPU_RDN;
      MEM_WRN0 = CPU_WRN0;
      MEM_WRN1 = CPU_WRN1;
    end else begin
      MEM_ADDR = cmd_q.addr;
      MEM_DOUT = cmd_q.wdata;
      MEM_RDN  = rdn_q;
      MEM_WRN0 = wrn0_q;
      MEM_WRN1 = wrn1_q;
    end
    if (!RESET) begin
      MEM_RDN  = 1'b1;
      MEM_WRN0 = 1'b1;
      MEM_WRN1 = 1'b1;
    end
  end

  // Hold rises in the boundary cycle itself; the grant follows one edge later.
  assign CPU_HOLD  = gnt_q | ((state == ARB_ST_HOLD_WAIT) & CPU_IDLE & DBG_REQ & RESET);
  assign DBG_GNT   = gnt_q;
  assign DBG_ACK   = ack_q;
  assign DBG_RDATA = rdata_q;

endmodule
